// File: rtl/lsu.sv
// Load/store unit between EXU and WBU: one memory access in flight at a time.
// Addresses go to memory 8-byte aligned; lanes are selected/shifted here.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_alu_result,
  input  logic [63:0] in_store_data,
  input  logic        in_mem_rd,
  input  logic        in_mem_wr,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        out_misalign,
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both 1; the sender holds its payload stable while valid && !ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] result_q;
  logic [1:0]  size_q;
  logic        rd_q;
  logic        wr_q;
  logic        uns_q;
  logic        mis_q;

  logic        accept;
  logic        in_mem;
  logic        in_mis;
  logic        capture;
  logic [2:0]  lane;
  logic [63:0] shifted;
  logic [63:0] load_val;
  logic [7:0]  wmask_base;

  assign accept = in_valid && in_ready;
  assign in_mem = in_mem_rd || in_mem_wr;
  assign lane   = addr_q[2:0];

  always_comb begin
    in_mis = 1'b0;
    unique case (in_size)
      2'd0:    in_mis = 1'b0;
      2'd1:    in_mis = in_alu_result[0];
      2'd2:    in_mis = |in_alu_result[1:0];
      default: in_mis = |in_alu_result[2:0];
    endcase
  end

  // Read data is taken only in WAIT, or in REQ when it arrives with the grant.
  assign capture = rd_q && mem_rvalid &&
                   ((state == REQ && mem_ready) || state == WAIT);

  assign shifted = mem_rdata >> {lane, 3'b000};

  always_comb begin
    load_val = shifted;
    unique case (size_q)
      2'd0:    load_val = {{56{~uns_q & shifted[7]}},  shifted[7:0]};
      2'd1:    load_val = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
      2'd2:    load_val = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    wmask_base = 8'h00;
    unique case (size_q)
      2'd0:    wmask_base = 8'h01;
      2'd1:    wmask_base = 8'h03;
      2'd2:    wmask_base = 8'h0F;
      default: wmask_base = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = (in_mem && !in_mis) ? REQ : DONE;
      REQ:  if (mem_ready) state_nx = (wr_q || mem_rvalid) ? DONE : WAIT;
      WAIT: if (mem_rvalid) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (state == IDLE);
    mem_req      = (state == REQ);
    mem_we       = mem_req && wr_q;
    mem_addr     = mem_req ? {addr_q[63:3], 3'b000} : 64'd0;
    mem_wdata    = mem_we ? (wdata_q << {lane, 3'b000}) : 64'd0;
    mem_wmask    = mem_we ? (wmask_base << lane) : 8'h00;
    out_valid    = (state == DONE);
    out_result   = result_q;
    out_misalign = mis_q;
    state_dbg    = state;
  end

  // Misaligned ops report 0; stores and ALU ops keep the passthrough value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      result_q <= 64'd0;
      size_q   <= 2'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      uns_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else if (accept) begin
      addr_q   <= in_alu_result;
      wdata_q  <= in_store_data;
      size_q   <= in_size;
      rd_q     <= in_mem_rd;
      wr_q     <= in_mem_wr;
      uns_q    <= in_unsigned;
      mis_q    <= in_mem && in_mis;
      result_q <= (in_mem && in_mis) ? 64'd0 : in_alu_result;
    end else if (capture) begin
      result_q <= load_val;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: drives ALU/load/store ops with random memory and
// WBU timing and compares against an arithmetic reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_alu_result = '0;
  logic [63:0] in_store_data = '0;
  logic        in_mem_rd = 1'b0;
  logic        in_mem_wr = 1'b0;
  logic [1:0]  in_size = '0;
  logic        in_unsigned = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        out_misalign;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
    .in_size(in_size), .in_unsigned(in_unsigned),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_misalign(out_misalign),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: take the addressed bytes, then sign/zero extend arithmetically.
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] addr,
                                             input logic [1:0] size, input logic uns);
    int          nbits;
    logic [63:0] v;
    logic [63:0] low;
    nbits = 8 << size;
    v = rdata >> (8 * (addr % 8));
    if (nbits == 64) return v;
    low = (64'd1 << nbits) - 64'd1;
    v = v & low;
    if (!uns && v[nbits-1]) v = v | ~low;
    return v;
  endfunction

  function automatic logic [7:0] model_wmask(input logic [63:0] addr, input logic [1:0] size);
    int m;
    m = ((1 << (1 << size)) - 1) << (addr % 8);
    return m[7:0];
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store. rv_dly < 0 means rvalid arrives with the grant.
  task automatic run_op(input int kind, input logic [63:0] addr, input logic [63:0] data,
                        input logic [63:0] rdata, input logic [1:0] size, input logic uns,
                        input int rdy_dly, input int rv_dly, input int out_dly);
    logic        mis;
    logic [63:0] exp_res;
    mis = (kind != 0) && ((addr % (64'd1 << size)) != 0);
    if (kind == 0)      exp_res = addr;
    else if (mis)       exp_res = 64'd0;
    else if (kind == 2) exp_res = addr;
    else                exp_res = model_load(rdata, addr, size, uns);
    exp_q.push_back(exp_res);

    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_mem_req", mem_req, 0);
    in_valid = 1'b1; in_alu_result = addr; in_store_data = data;
    in_mem_rd = (kind == 1); in_mem_wr = (kind == 2);
    in_size = size; in_unsigned = uns;
    @(negedge clk);
    in_valid = 1'b0;
    in_alu_result = {$urandom, $urandom}; in_store_data = {$urandom, $urandom};
    in_mem_rd = 1'b0; in_mem_wr = 1'b0; in_size = 2'($urandom_range(0, 3));
    in_unsigned = 1'($urandom_range(0, 1));

    if (kind != 0 && !mis) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        check("req_mem_req", mem_req, 1);
        check("req_in_ready", in_ready, 0);
        check("req_mem_addr", mem_addr, addr & ~64'd7);
        check("req_mem_we", mem_we, (kind == 2));
        check("req_mem_wmask", mem_wmask, (kind == 2) ? model_wmask(addr, size) : 8'h00);
        if (kind == 2) check("req_mem_wdata", mem_wdata, data << (8 * (addr % 8)));
        if (i < rdy_dly) begin
          mem_ready = 1'b0;
          mem_rvalid = 1'($urandom_range(0, 1));
          mem_rdata = ~rdata;
        end else begin
          mem_ready = 1'b1;
          mem_rvalid = (kind == 1 && rv_dly < 0);
          mem_rdata = rdata;
        end
        @(negedge clk);
      end
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (kind == 1 && rv_dly >= 0) begin
        for (int i = 0; i <= rv_dly; i++) begin
          check("wait_mem_req", mem_req, 0);
          check("wait_out_valid", out_valid, 0);
          check("wait_in_ready", in_ready, 0);
          mem_rvalid = (i == rv_dly);
          mem_rdata = rdata;
          @(negedge clk);
        end
        mem_rvalid = 1'b0;
      end
    end

    for (int i = 0; i <= out_dly; i++) begin
      check("done_out_valid", out_valid, 1);
      check("done_in_ready", in_ready, 0);
      check("done_mem_req", mem_req, 0);
      check("done_mem_we", mem_we, 0);
      check("done_mem_wmask", mem_wmask, 0);
      check("done_misalign", out_misalign, mis);
      if (i == out_dly) check("sb_result", out_result, exp_q.pop_front());
      else              check("done_result", out_result, exp_res);
      out_ready = (i == out_dly);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = ~rdata;
      @(negedge clk);
    end
    out_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_misalign"}, out_misalign, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_wmask"}, mem_wmask, 0);
    check({tag, "_out_result"}, out_result, 0);
  endtask

  // Start an aligned dword load, optionally let it reach WAIT, then reset.
  task automatic reset_mid(input logic to_wait);
    in_valid = 1'b1; in_alu_result = 64'h3008; in_mem_rd = 1'b1; in_mem_wr = 1'b0;
    in_size = 2'd3; in_unsigned = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_mem_rd = 1'b0;
    check("rm_req", mem_req, 1);
    if (to_wait) begin
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      check("rm_wait_req", mem_req, 0);
      check("rm_wait_in_ready", in_ready, 0);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("rm_async");
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rm_after_out_valid", out_valid, 0);
      check("rm_after_in_ready", in_ready, 1);
      check("rm_after_mem_req", mem_req, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 64'h1234, 64'h0, 64'h0, 2'd0, 1'b0, 0, 0, 0);
    run_op(1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 2'd0, 1'b0, 0, 0, 0);
    run_op(1, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 2'd0, 1'b1, 0, 0, 0);
    run_op(2, 64'h2006, 64'hABCD, 64'h0, 2'd1, 1'b0, 3, 0, 0);
    run_op(1, 64'h1002, 64'h0, 64'h0, 2'd2, 1'b0, 0, 0, 0);
    run_op(1, 64'h4000, 64'h0, 64'h8877_6655_4433_2211, 2'd3, 1'b1, 1, 2, 4);
    run_op(1, 64'h5004, 64'h0, 64'h8000_0001_0000_0000, 2'd2, 1'b0, 0, -1, 0);
    run_op(1, 64'h5004, 64'h0, 64'h8000_0001_0000_0000, 2'd2, 1'b1, 2, -1, 1);

    reset_mid(1'b1);
    reset_mid(1'b0);

    for (int n = 0; n < 80; n++) begin
      int          kind;
      logic [1:0]  size;
      logic [63:0] addr;
      kind = $urandom_range(0, 2);
      size = 2'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
      run_op(kind, addr, {$urandom, $urandom}, {$urandom, $urandom}, size,
             1'($urandom_range(0, 1)), $urandom_range(0, 3),
             int'($urandom_range(0, 4)) - 1, $urandom_range(0, 3));
    end

    check("sb_queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
